// File: rtl/output_interface_reader.sv
// Host-side reader for the 16-bit output pin interface: strobes four beats per
// buffered word out of the transmitter, reassembles them and offers the word downstream.
module output_interface_reader #(
  parameter int WORD_W      = 64,
  parameter int BUS_W       = 16,
  parameter int BEATS       = 4,
  parameter int HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              data_ready,
  input  logic              finish,
  input  logic [BUS_W-1:0]  bus_in,
  output logic              rd_strobe,
  output logic              rd_req_n,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [15:0]       word_count,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [7:0] LAST_PHASE = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_STROBE_HI,
    S_STROBE_LO,
    S_DELIVER,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic [7:0]        phase, phase_n;
  logic              rd_strobe_n, rd_req_n_n, word_valid_n, busy_n, done_n;
  logic [WORD_W-1:0] word_out_n;
  logic [15:0]       word_count_n;
  logic              data_ready_m, data_ready_s, finish_m, finish_s;

  // Pin handshakes come from another clock domain, so only their double-registered copies steer the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ready_m <= 1'b0;
      data_ready_s <= 1'b0;
      finish_m     <= 1'b0;
      finish_s     <= 1'b0;
    end else begin
      data_ready_m <= data_ready;
      data_ready_s <= data_ready_m;
      finish_m     <= finish;
      finish_s     <= finish_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      beat       <= '0;
      phase      <= '0;
      rd_strobe  <= 1'b0;
      rd_req_n   <= 1'b1;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      phase      <= phase_n;
      rd_strobe  <= rd_strobe_n;
      rd_req_n   <= rd_req_n_n;
      word_out   <= word_out_n;
      word_valid <= word_valid_n;
      word_count <= word_count_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    beat_n       = beat;
    phase_n      = phase;
    rd_strobe_n  = rd_strobe;
    rd_req_n_n   = rd_req_n;
    word_out_n   = word_out;
    word_valid_n = word_valid;
    word_count_n = word_count;
    busy_n       = busy;
    done_n       = done;

    // Abort drops any partial word but keeps the count of words already handed off.
    if (state != S_IDLE && abort) begin
      state_n      = S_IDLE;
      beat_n       = '0;
      phase_n      = '0;
      rd_strobe_n  = 1'b0;
      rd_req_n_n   = 1'b1;
      word_valid_n = 1'b0;
      busy_n       = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state_n      = S_WAIT_RDY;
            rd_req_n_n   = 1'b0;
            busy_n       = 1'b1;
            done_n       = 1'b0;
            word_count_n = '0;
            beat_n       = '0;
          end
        end
        S_WAIT_RDY: begin
          if (data_ready_s) begin
            state_n     = S_STROBE_HI;
            phase_n     = '0;
            rd_strobe_n = 1'b1;
          end else if (finish_s) begin
            state_n = S_DONE;
          end
        end
        S_STROBE_HI: begin
          if (phase == LAST_PHASE) begin
            state_n     = S_STROBE_LO;
            phase_n     = '0;
            rd_strobe_n = 1'b0;
          end else begin
            phase_n = phase + 8'd1;
          end
        end
        S_STROBE_LO: begin
          if (phase == LAST_PHASE) begin
            phase_n = '0;
            word_out_n[BUS_W*int'(beat) +: BUS_W] = bus_in;
            if (beat == LAST_BEAT) begin
              beat_n       = '0;
              word_valid_n = 1'b1;
              state_n      = S_DELIVER;
            end else begin
              beat_n      = beat + BEAT_W'(1);
              rd_strobe_n = 1'b1;
              state_n     = S_STROBE_HI;
            end
          end else begin
            phase_n = phase + 8'd1;
          end
        end
        S_DELIVER: begin
          if (word_ready) begin
            word_valid_n = 1'b0;
            if (word_count != 16'hFFFF) word_count_n = word_count + 16'd1;
            state_n = S_WAIT_RDY;
          end
        end
        S_DONE: begin
          rd_req_n_n = 1'b1;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          state_n    = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_interface_reader.sv
// Bench for output_interface_reader: a transmitter model feeds halfwords on strobe rises,
// a scoreboard queue holds the words expected downstream, and a monitor checks pin timing.
module tb_output_interface_reader;

  localparam int HP    = 2;
  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort, finish, word_ready;
  logic        data_ready;
  logic [15:0] bus_in = '0;
  logic        rd_strobe, rd_req_n, word_valid, busy, done;
  logic [63:0] word_out;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] tx_words[64];
  int tx_count = 0;
  int tx_idx   = 0;
  int tx_beat  = 0;
  logic tx_prev_strobe = 1'b0;

  int delivered = 0;
  int rises = 0, hi_len = 0, lo_len = 0;
  bit skip = 1'b0, mon_prev_strobe = 1'b0, held = 1'b0, accepted_last = 1'b0;
  logic [63:0] held_word = '0;

  output_interface_reader #(
    .WORD_W(64), .BUS_W(16), .BEATS(BEATS), .HALF_PERIOD(HP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .data_ready(data_ready), .finish(finish), .bus_in(bus_in),
    .rd_strobe(rd_strobe), .rd_req_n(rd_req_n), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .word_count(word_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign data_ready = (tx_idx < tx_count);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: actual=timeout required=event", name);
  endtask

  task automatic applyStimulus(input logic [63:0] w, input bit expect_out);
    tx_words[tx_count] = w;
    tx_count++;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitWords(input int target, input string name);
    int n;
    n = 0;
    while (delivered < target && n < 2000) begin
      tick();
      n++;
    end
    if (delivered < target) timeoutFail(name);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (done !== 1'b1) timeoutFail(name);
  endtask

  task automatic waitStrobeRises(input int count, input string name);
    int seen, cyc;
    logic prev;
    seen = 0;
    cyc  = 0;
    prev = rd_strobe;
    while (seen < count && cyc < 500) begin
      tick();
      cyc++;
      if (rd_strobe && !prev) seen++;
      prev = rd_strobe;
    end
    if (seen < count) timeoutFail(name);
  endtask

  // Transmitter model: a new halfword appears on each strobe rise, least-significant first.
  always @(negedge clk) begin
    if (reset) begin
      tx_beat        = 0;
      tx_prev_strobe = 1'b0;
    end else begin
      if (rd_strobe && !tx_prev_strobe && tx_idx < tx_count) begin
        bus_in = tx_words[tx_idx][16*tx_beat +: 16];
        if (tx_beat == BEATS - 1) begin
          tx_beat = 0;
          tx_idx++;
        end else begin
          tx_beat++;
        end
      end else if (abort && tx_beat != 0) begin
        tx_beat = 0;
        tx_idx++;
      end
      tx_prev_strobe = rd_strobe;
    end
  end

  // Monitor: scoreboard pop on each accepted word plus strobe shape and backpressure checks.
  always @(negedge clk) begin
    if (reset) begin
      rises = 0; hi_len = 0; lo_len = 0; skip = 1'b0;
      mon_prev_strobe = 1'b0; held = 1'b0; accepted_last = 1'b0;
    end else begin
      if (abort) begin
        skip  = 1'b1;
        rises = 0;
      end
      if (rd_strobe && !mon_prev_strobe) begin
        if (!skip && rises >= 1 && rises <= BEATS - 1) checkOutput("strobe_low_len", 64'(lo_len), 64'(HP));
        rises++;
        hi_len = 1;
      end else if (rd_strobe) begin
        hi_len++;
      end else if (mon_prev_strobe) begin
        if (!skip) checkOutput("strobe_high_len", 64'(hi_len), 64'(HP));
        skip   = 1'b0;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      mon_prev_strobe = rd_strobe;

      if (accepted_last) checkOutput("valid_one_cycle", 64'(word_valid), 64'(0));
      if (held) begin
        checkOutput("bp_word_stable", word_out, held_word);
        checkOutput("bp_no_strobe", 64'(rd_strobe), 64'(0));
      end

      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: actual=%0h required=none", word_out);
        end else begin
          checkOutput("word", word_out, exp_q.pop_front());
        end
        checkOutput("strobes_per_word", 64'(rises), 64'(BEATS));
        rises = 0;
        delivered++;
      end
      accepted_last = word_valid && word_ready;
      held          = word_valid && !word_ready;
      held_word     = word_out;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=hung required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; finish = 1'b0; word_ready = 1'b1;
    repeat (3) tick();
    checkOutput("rst_strobe", 64'(rd_strobe), 64'(0));
    checkOutput("rst_req_n", 64'(rd_req_n), 64'(1));
    checkOutput("rst_word_out", word_out, 64'h0);
    checkOutput("rst_valid", 64'(word_valid), 64'(0));
    checkOutput("rst_count", 64'(word_count), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    reset = 1'b0;
    tick();

    $display("[TB] start with abort in the same cycle");
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    checkOutput("abort_start_busy", 64'(busy), 64'(0));
    checkOutput("abort_start_req_n", 64'(rd_req_n), 64'(1));

    $display("[TB] single word");
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b1);
    pulseStart();
    checkOutput("single_busy", 64'(busy), 64'(1));
    checkOutput("single_req_n", 64'(rd_req_n), 64'(0));
    waitWords(1, "single_word_wait");
    checkOutput("single_count", 64'(word_count), 64'(1));
    finish = 1'b1;
    waitDone("single_done_wait");
    checkOutput("single_done_busy", 64'(busy), 64'(0));
    checkOutput("single_done_req_n", 64'(rd_req_n), 64'(1));
    finish = 1'b0;
    repeat (4) tick();

    $display("[TB] reset during beat 2");
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b1);
    pulseStart();
    checkOutput("restart_clears_done", 64'(done), 64'(0));
    waitStrobeRises(3, "reset_beat2_wait");
    reset = 1'b1;
    #1;
    checkOutput("midrst_strobe", 64'(rd_strobe), 64'(0));
    checkOutput("midrst_req_n", 64'(rd_req_n), 64'(1));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_word_out", word_out, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    base = delivered;
    pulseStart();
    waitWords(base + 1, "after_reset_word_wait");
    checkOutput("after_reset_count", 64'(word_count), 64'(1));
    finish = 1'b1;
    waitDone("after_reset_done_wait");
    finish = 1'b0;
    repeat (4) tick();

    $display("[TB] three-word stream");
    applyStimulus(64'hFFFF_FFFF_0000_0000, 1'b1);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 1'b1);
    applyStimulus(64'hFFFF_0000_0000_FFFF, 1'b1);
    base = delivered;
    pulseStart();
    checkOutput("stream_done_cleared", 64'(done), 64'(0));
    waitWords(base + 3, "stream_wait");
    finish = 1'b1;
    waitDone("stream_done_wait");
    checkOutput("stream_count", 64'(word_count), 64'(3));
    checkOutput("stream_busy", 64'(busy), 64'(0));
    checkOutput("stream_req_n", 64'(rd_req_n), 64'(1));
    finish = 1'b0;
    repeat (4) tick();

    $display("[TB] backpressure");
    word_ready = 1'b0;
    applyStimulus(64'h1234_5678_9ABC_DEF0, 1'b1);
    applyStimulus(64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    base = delivered;
    pulseStart();
    n = 0;
    while (word_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (word_valid !== 1'b1) timeoutFail("bp_valid_wait");
    repeat (20) begin
      tick();
      checkOutput("bp_hold_valid", 64'(word_valid), 64'(1));
      checkOutput("bp_hold_word", word_out, 64'h1234_5678_9ABC_DEF0);
    end
    word_ready = 1'b1;
    waitWords(base + 2, "bp_release_wait");
    checkOutput("bp_count", 64'(word_count), 64'(2));
    finish = 1'b1;
    waitDone("bp_done_wait");
    finish = 1'b0;
    repeat (4) tick();

    $display("[TB] finish during beat 1 with more data pending");
    applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    applyStimulus(64'h0000_FFFF_0000_FFFF, 1'b1);
    base = delivered;
    pulseStart();
    waitStrobeRises(2, "finish_beat1_wait");
    finish = 1'b1;
    waitDone("finish_mid_done_wait");
    checkOutput("finish_mid_count", 64'(word_count), 64'(2));
    checkOutput("finish_mid_delivered", 64'(delivered - base), 64'(2));
    checkOutput("finish_mid_busy", 64'(busy), 64'(0));
    finish = 1'b0;
    repeat (4) tick();

    $display("[TB] abort during beat 3");
    applyStimulus(64'h1111_2222_3333_4444, 1'b1);
    applyStimulus(64'h5555_6666_7777_8888, 1'b0);
    base = delivered;
    pulseStart();
    waitWords(base + 1, "abort_first_word_wait");
    waitStrobeRises(4, "abort_beat3_wait");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_req_n", 64'(rd_req_n), 64'(1));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_valid", 64'(word_valid), 64'(0));
    checkOutput("abort_done", 64'(done), 64'(0));
    checkOutput("abort_count", 64'(word_count), 64'(1));
    checkOutput("abort_strobe", 64'(rd_strobe), 64'(0));
    repeat (10) tick();
    checkOutput("abort_still_idle", 64'(busy), 64'(0));
    checkOutput("abort_no_late_valid", 64'(word_valid), 64'(0));

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
